// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - RV32I load/store initiator for a byte-lane data memory
// Validates width/alignment, drives one memory access, extends load data, stalls while busy.
module lsu_mem_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              off_q, off_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [3:0]              mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic [1:0]              resp_err_q, resp_err_d;

  logic                    f3_illegal, misaligned;
  logic [3:0]              be_new;
  logic [31:0]             wdata_new;
  logic [15:0]             sh;
  logic [31:0]             load_ext;

  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q == REQ) || (state_q == WAIT) || (state_q == IDLE && req_valid);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Stores only have the signed encodings; unsigned widths are load-only.
  always_comb begin
    f3_illegal = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
      3'b100, 3'b101:         f3_illegal = req_write;
      default:                f3_illegal = 1'b1;
    endcase
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    be_new    = 4'b1111;
    wdata_new = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << req_addr[1:0];
        wdata_new = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << req_addr[1:0];
        wdata_new = {2{req_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = req_wdata;
      end
    endcase
  end

  assign sh = 16'(mem_rdata >> {off_q, 3'b000});

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_ext = {24'b0, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  load_ext = {16'b0, sh[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d      = req_write;
          funct3_d     = req_funct3;
          off_d        = req_addr[1:0];
          cnt_d        = '0;
          resp_rdata_d = 32'b0;
          if (f3_illegal) begin
            resp_err_d = 2'b10;
            state_d    = RESP;
          end else if (misaligned) begin
            resp_err_d = 2'b01;
            state_d    = RESP;
          end else begin
            resp_err_d  = 2'b00;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q >= CNT_LAST) begin
          resp_err_d = 2'b11;
          state_d    = RESP;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid) begin
          resp_rdata_d = write_q ? 32'b0 : load_ext;
          state_d      = RESP;
        end else if (cnt_q >= CNT_LAST) begin
          resp_err_d = 2'b11;
          state_d    = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    // Request strobes and the response pulse are registered from the next state.
    mem_req_d    = (state_d == REQ);
    mem_we_d     = (state_d == REQ) && write_d;
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      funct3_q     <= 3'b0;
      off_q        <= 2'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 2'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - directed self-checking bench for lsu_mem_initiator
// Memory side is scripted cycle by cycle; expected values are hand-computed constants.
module tb_lsu_mem_initiator;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_initiator #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle, then scrambles the request inputs.
  task automatic issue(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    check({tag, ".accept_stall"}, stall, 1);
    check({tag, ".accept_ready"}, req_ready, 1);
    tick();
    req_valid  = 1'b0;
    req_write  = ~w;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h0;
  endtask

  task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int gnt_dly,
                     input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                     input logic [31:0] exp_rdata);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    issue(tag, w, f3, addr, wdata);
    for (int i = 0; i < gnt_dly; i++) begin
      check({tag, ".req_hold"}, mem_req, 1);
      check({tag, ".stall_req"}, stall, 1);
      check({tag, ".addr_hold"}, mem_addr, exp_addr);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      tick();
      mem_rvalid = 1'b0;
    end
    check({tag, ".mem_req"}, mem_req, 1);
    check({tag, ".addr"}, mem_addr, exp_addr);
    check({tag, ".be"}, {28'b0, mem_be}, {28'b0, exp_be});
    check({tag, ".we"}, mem_we, w);
    if (w) check({tag, ".wdata"}, mem_wdata, exp_wdata);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({tag, ".req_drop"}, mem_req, 0);
    check({tag, ".stall_wait"}, stall, 1);
    check({tag, ".no_early_resp"}, resp_valid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    check({tag, ".resp_valid"}, resp_valid, 1);
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".err"}, {30'b0, resp_err}, 0);
    check({tag, ".stall_resp"}, stall, 0);
    check({tag, ".ready_resp"}, req_ready, 0);
    tick();
    check({tag, ".resp_pulse"}, resp_valid, 0);
    check({tag, ".ready_idle"}, req_ready, 1);
  endtask

  task automatic err_case(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] exp_err);
    issue(tag, w, f3, addr, 32'h5A5A_5A5A);
    check({tag, ".no_mem_req"}, mem_req, 0);
    check({tag, ".resp_valid"}, resp_valid, 1);
    check({tag, ".err"}, {30'b0, resp_err}, {30'b0, exp_err});
    check({tag, ".rdata"}, resp_rdata, 0);
    check({tag, ".stall"}, stall, 0);
    tick();
    check({tag, ".resp_pulse"}, resp_valid, 0);
    check({tag, ".no_mem_req2"}, mem_req, 0);
  endtask

  // Timeout after the 16th counted cycle; optional grant in the first REQ cycle.
  task automatic timeout_case(input string tag, input logic give_gnt);
    logic seen_resp;
    logic req_gap;
    seen_resp = 1'b0;
    req_gap   = 1'b0;
    issue(tag, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      seen_resp = seen_resp | resp_valid;
      if (!give_gnt) req_gap = req_gap | ~mem_req;
      mem_gnt = give_gnt && (i == 1);
      tick();
      mem_gnt = 1'b0;
    end
    check({tag, ".no_early_resp"}, seen_resp, 0);
    check({tag, ".req_held"}, req_gap, 0);
    check({tag, ".resp_valid"}, resp_valid, 1);
    check({tag, ".err"}, {30'b0, resp_err}, 3);
    check({tag, ".rdata"}, resp_rdata, 0);
    check({tag, ".req_drop"}, mem_req, 0);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    check({tag, ".stray_rvalid"}, resp_valid, 0);
    tick();
    check({tag, ".stray_rvalid2"}, resp_valid, 0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    check("rst.ready", req_ready, 1);
    check("rst.stall", stall, 0);
    check("rst.mem_req", mem_req, 0);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.be", {28'b0, mem_be}, 0);
    check("rst.err", {30'b0, resp_err}, 0);
    reset = 1'b0;
    tick();

    txn("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    txn("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF_7F01, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
    txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF_7F01, 0, 4'b1000, 32'h0, 32'h0000_0080);
    txn("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 32'h80FF_7F01, 1, 4'b0010, 32'h0, 32'h0000_007F);
    txn("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'h80FF_7F01, 0, 4'b1100, 32'h0, 32'hFFFF_80FF);
    txn("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h80FF_7F01, 0, 4'b1100, 32'h0, 32'h0000_80FF);
    txn("sh22",  1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 32'h5555_5555, 3, 4'b1100, 32'hABCD_ABCD, 32'h0);
    txn("sb01",  1'b1, 3'b000, 32'h01, 32'h0000_00A5, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    txn("sw08",  1'b1, 3'b010, 32'h08, 32'h1122_3344, 32'h0, 2, 4'b1111, 32'h1122_3344, 32'h0);

    err_case("lw05_mis",  1'b0, 3'b010, 32'h05, 2'b01);
    err_case("lh07_mis",  1'b0, 3'b001, 32'h07, 2'b01);
    err_case("sw02_mis",  1'b1, 3'b010, 32'h02, 2'b01);
    err_case("ld011_ill", 1'b0, 3'b011, 32'h00, 2'b10);
    err_case("st100_ill", 1'b1, 3'b100, 32'h00, 2'b10);

    timeout_case("to_wait", 1'b1);
    timeout_case("to_req",  1'b0);

    issue("rst_mid", 1'b0, 3'b010, 32'h30, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rst_mid.in_wait", stall, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid.stall", stall, 0);
    check("rst_mid.addr", mem_addr, 0);
    check("rst_mid.be", {28'b0, mem_be}, 0);
    check("rst_mid.mem_req", mem_req, 0);
    check("rst_mid.resp_valid", resp_valid, 0);
    check("rst_mid.ready", req_ready, 1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    txn("lw_after_rst", 1'b0, 3'b010, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 4'b1111, 32'h0, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
